// File: rtl/cpu_types_pkg.sv
// Shared CPU types: data word, ALU opcode set and the ALU arbiter FSM state.
// Opcode encodings 11..15 are deliberately unassigned; the ALU returns 0 for them.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [3:0] {
        ALU_SLL  = 4'd0,
        ALU_SRL  = 4'd1,
        ALU_SRA  = 4'd2,
        ALU_ADD  = 4'd3,
        ALU_SUB  = 4'd4,
        ALU_AND  = 4'd5,
        ALU_OR   = 4'd6,
        ALU_XOR  = 4'd7,
        ALU_NOR  = 4'd8,
        ALU_SLT  = 4'd9,
        ALU_SLTU = 4'd10
    } aluop_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arbstate_t;

    // Requester id to one-hot strobe for the two-requester buses.
    function automatic logic [1:0] onehot2(input logic id);
        return {id, ~id};
    endfunction

endpackage

// File: rtl/alu.sv
// Purely combinational 32-bit ALU with negative/overflow/zero flags.
// Overflow is only produced by ADD and SUB; unknown opcodes give result 0.
module alu
    import cpu_types_pkg::*;
(
    input  aluop_t op_i,
    input  word_t  a_i,
    input  word_t  b_i,
    output word_t  result_o,
    output logic   negative_o,
    output logic   overflow_o,
    output logic   zero_o
);

    word_t sum;
    word_t diff;

    assign sum  = a_i + b_i;
    assign diff = a_i - b_i;

    always_comb begin
        result_o   = '0;
        overflow_o = 1'b0;
        case (op_i)
            ALU_SLL:  result_o = a_i << b_i[4:0];
            ALU_SRL:  result_o = a_i >> b_i[4:0];
            ALU_SRA:  result_o = $signed(a_i) >>> b_i[4:0];
            ALU_ADD: begin
                result_o   = sum;
                // Signed overflow: like-signed operands producing a result of the other sign.
                overflow_o = (a_i[31] == b_i[31]) && (sum[31] != a_i[31]);
            end
            ALU_SUB: begin
                result_o   = diff;
                overflow_o = (a_i[31] != b_i[31]) && (diff[31] != a_i[31]);
            end
            ALU_AND:  result_o = a_i & b_i;
            ALU_OR:   result_o = a_i | b_i;
            ALU_XOR:  result_o = a_i ^ b_i;
            ALU_NOR:  result_o = ~(a_i | b_i);
            ALU_SLT:  result_o = {31'b0, ($signed(a_i) < $signed(b_i))};
            ALU_SLTU: result_o = {31'b0, (a_i < b_i)};
            default:  result_o = '0;
        endcase
    end

    assign negative_o = result_o[31];
    assign zero_o     = (result_o == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Serialises two requesters onto one ALU, one operation in flight (IDLE -> EXEC -> RESP).
// Define ALU_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module alu_arbiter
    import cpu_types_pkg::*;
(
    input  logic         CLK,
    input  logic         nRST,
    input  logic [1:0]   req_valid,
    output logic [1:0]   req_ready,
    input  aluop_t [1:0] req_aluop,
    input  word_t [1:0]  req_a,
    input  word_t [1:0]  req_b,
    output logic [1:0]   rsp_valid,
    input  logic [1:0]   rsp_ready,
    output word_t        rsp_result,
    output logic         rsp_negative,
    output logic         rsp_overflow,
    output logic         rsp_zero
);

    // Handshakes: a request moves on the edge where req_valid[i] & req_ready[i], a response on
    // the edge where rsp_valid[i] & rsp_ready[i]; rsp_valid/result/flags hold until accepted.

    arbstate_t state_q, state_d;
    logic      owner_q, owner_d;
    aluop_t    op_q, op_d;
    word_t     a_q, a_d;
    word_t     b_q, b_d;
    word_t     result_q, result_d;
    logic      neg_q, neg_d;
    logic      ovf_q, ovf_d;
    logic      zero_q, zero_d;

    logic      accept;
    logic      grant_id;

    word_t     alu_result;
    logic      alu_negative;
    logic      alu_overflow;
    logic      alu_zero;

`ifdef ALU_ARB_RR_EN
    logic      last_q, last_d;

    always_comb begin
        grant_id = req_valid[1];
        if (req_valid == 2'b11) begin
            grant_id = ~last_q;
        end
    end

    always_comb begin
        last_d = last_q;
        if (accept) begin
            last_d = grant_id;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`else
    always_comb begin
        grant_id = ~req_valid[0];
    end
`endif

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    accept  = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: state_d = RESP;
            RESP: begin
                // Only the owner's rsp_ready can release the response.
                if (rsp_ready[owner_q]) begin
                    if (|req_valid) begin
                        accept  = 1'b1;
                        state_d = EXEC;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        owner_d  = owner_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        neg_d    = neg_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        if (accept) begin
            owner_d = grant_id;
            op_d    = req_aluop[grant_id];
            a_d     = req_a[grant_id];
            b_d     = req_b[grant_id];
        end
        if (state_q == EXEC) begin
            result_d = alu_result;
            neg_d    = alu_negative;
            ovf_d    = alu_overflow;
            zero_d   = alu_zero;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            op_q     <= ALU_SLL;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            neg_q    <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            neg_q    <= neg_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

    alu u_alu (
        .op_i       (op_q),
        .a_i        (a_q),
        .b_i        (b_q),
        .result_o   (alu_result),
        .negative_o (alu_negative),
        .overflow_o (alu_overflow),
        .zero_o     (alu_zero)
    );

    // Gating with nRST keeps req_ready low for the whole reset, even while idle with requests pending.
    assign req_ready    = (accept ? onehot2(grant_id) : 2'b00) & {2{nRST}};
    assign rsp_valid    = (state_q == RESP) ? onehot2(owner_q) : 2'b00;
    assign rsp_result   = result_q;
    assign rsp_negative = neg_q;
    assign rsp_overflow = ovf_q;
    assign rsp_zero     = zero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed vector table, hand-written corner sequences and a
// randomized phase scored against a transaction-level model. Honours ALU_ARB_RR_EN.
module tb_alu_arbiter;
    import cpu_types_pkg::*;

`ifdef ALU_ARB_RR_EN
    localparam bit RR_MODE = 1'b1;
`else
    localparam bit RR_MODE = 1'b0;
`endif

    logic         CLK;
    logic         nRST;
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    aluop_t [1:0] req_aluop;
    word_t [1:0]  req_a;
    word_t [1:0]  req_b;
    logic [1:0]   rsp_valid;
    logic [1:0]   rsp_ready;
    word_t        rsp_result;
    logic         rsp_negative;
    logic         rsp_overflow;
    logic         rsp_zero;

    int checks = 0;
    int errors = 0;

    // {negative, overflow, zero, result}
    logic [34:0] exp_q[$];

    typedef struct {
        logic        idx;
        aluop_t      op;
        word_t       a;
        word_t       b;
        word_t       res;
        logic [2:0]  fl;
    } vec_t;

    vec_t vecs[15];

    logic   pend_v  [2];
    aluop_t pend_op [2];
    word_t  pend_a  [2];
    word_t  pend_b  [2];
    bit     m_busy;
    logic   m_owner;
    int     m_age;
    logic   m_last;

    alu_arbiter dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_aluop    (req_aluop),
        .req_a        (req_a),
        .req_b        (req_b),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_negative (rsp_negative),
        .rsp_overflow (rsp_overflow),
        .rsp_zero     (rsp_zero)
    );

    // Clock / reset
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [34:0] rsp_bus();
        return {rsp_negative, rsp_overflow, rsp_zero, rsp_result};
    endfunction

    // Reference ALU from plain signed/unsigned arithmetic.
    function automatic logic [34:0] ref_alu(input aluop_t op, input word_t a, input word_t b);
        longint sa;
        longint sb;
        longint s;
        word_t  r;
        logic   v;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        s  = 0;
        r  = '0;
        v  = 1'b0;
        case (op)
            ALU_SLL:  r = a << b[4:0];
            ALU_SRL:  r = a >> b[4:0];
            ALU_SRA:  r = $signed(a) >>> b[4:0];
            ALU_ADD: begin
                s = sa + sb;
                r = s[31:0];
                v = (s != longint'($signed(r)));
            end
            ALU_SUB: begin
                s = sa - sb;
                r = s[31:0];
                v = (s != longint'($signed(r)));
            end
            ALU_AND:  r = a & b;
            ALU_OR:   r = a | b;
            ALU_XOR:  r = a ^ b;
            ALU_NOR:  r = ~(a | b);
            ALU_SLT:  r = (sa < sb) ? 32'd1 : 32'd0;
            ALU_SLTU: r = (a < b) ? 32'd1 : 32'd0;
            default:  r = '0;
        endcase
        return {r[31], v, (r == 32'd0), r};
    endfunction

    function automatic logic pick_req(input logic v0, input logic v1, input logic last);
        if (v0 && v1) return RR_MODE ? ~last : 1'b0;
        return v1;
    endfunction

    function automatic word_t rnd_word();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom();
        endcase
    endfunction

    // Driver tasks
    task automatic do_reset();
        @(negedge CLK);
        nRST      = 1'b0;
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        repeat (2) @(negedge CLK);
        nRST = 1'b1;
    endtask

    task automatic do_op(input int tag, input logic idx, input aluop_t op,
                         input word_t a, input word_t b, input logic [34:0] exp);
        int w;
        logic [1:0] oh;
        oh = idx ? 2'b10 : 2'b01;
        @(negedge CLK);
        req_aluop[idx] = op;
        req_a[idx]     = a;
        req_b[idx]     = b;
        req_valid      = oh;
        rsp_ready      = 2'b00;
        #1;
        w = 0;
        while (req_ready !== oh && w < 10) begin
            @(negedge CLK);
            #1;
            w++;
        end
        check($sformatf("op%0d_grant", tag), req_ready, oh);
        @(negedge CLK);
        req_valid = 2'b00;
        #1;
        check($sformatf("op%0d_exec_no_rsp", tag), rsp_valid, 2'b00);
        @(negedge CLK);
        #1;
        check($sformatf("op%0d_rsp_valid", tag), rsp_valid, oh);
        check($sformatf("op%0d_rsp_data", tag), rsp_bus(), exp);
        rsp_ready = oh;
        @(negedge CLK);
        rsp_ready = 2'b00;
        #1;
        check($sformatf("op%0d_rsp_done", tag), rsp_valid, 2'b00);
    endtask

    initial begin
        nRST      = 1'b1;
        req_valid = 2'b11;
        rsp_ready = 2'b00;
        req_aluop = {ALU_ADD, ALU_ADD};
        req_a     = '0;
        req_b     = '0;

        vecs[0]  = '{1'b0, ALU_ADD,  32'h0000_0005, 32'h0000_0003, 32'h0000_0008, 3'b000};
        vecs[1]  = '{1'b1, ALU_ADD,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 3'b110};
        vecs[2]  = '{1'b0, ALU_SUB,  32'h0000_0004, 32'h0000_0004, 32'h0000_0000, 3'b001};
        vecs[3]  = '{1'b1, ALU_SUB,  32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 3'b010};
        vecs[4]  = '{1'b0, ALU_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 3'b000};
        vecs[5]  = '{1'b1, ALU_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 3'b001};
        vecs[6]  = '{1'b0, ALU_AND,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 3'b100};
        vecs[7]  = '{1'b1, ALU_OR,   32'h0F0F_0000, 32'h0000_00F0, 32'h0F0F_00F0, 3'b000};
        vecs[8]  = '{1'b0, ALU_XOR,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 3'b001};
        vecs[9]  = '{1'b1, ALU_NOR,  32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 3'b100};
        vecs[10] = '{1'b0, ALU_SLL,  32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 3'b100};
        vecs[11] = '{1'b1, ALU_SRL,  32'h8000_0000, 32'h0000_0004, 32'h0800_0000, 3'b000};
        vecs[12] = '{1'b0, ALU_SRA,  32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 3'b100};
        vecs[13] = '{1'b1, ALU_ADD,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 3'b001};
        vecs[14] = '{1'b0, aluop_t'(4'hF), 32'h0000_0005, 32'h0000_0003, 32'h0000_0000, 3'b001};

        // Reset state, with both requesters already asking.
        #1 nRST = 1'b0;
        #2;
        check("reset_req_ready", req_ready, 2'b00);
        check("reset_rsp_valid", rsp_valid, 2'b00);
        check("reset_rsp_data", rsp_bus(), 35'd0);
        do_reset();

        // Directed vector table
        for (int i = 0; i < 15; i++) begin
            do_op(i, vecs[i].idx, vecs[i].op, vecs[i].a, vecs[i].b, {vecs[i].fl, vecs[i].res});
        end

        // Randomized traffic against the transaction model
        do_reset();
        m_busy  = 1'b0;
        m_owner = 1'b0;
        m_age   = 0;
        m_last  = 1'b1;
        pend_v  = '{1'b0, 1'b0};
        exp_q.delete();
        for (int cyc = 0; cyc < 400; cyc++) begin
            logic [1:0] exp_rv;
            logic [1:0] exp_rr;
            logic       can;
            logic       any;
            logic       g;
            @(negedge CLK);
            for (int i = 0; i < 2; i++) begin
                if (!pend_v[i] && $urandom_range(0, 2) != 0) begin
                    pend_v[i]  = 1'b1;
                    pend_op[i] = aluop_t'(4'($urandom_range(0, 15)));
                    pend_a[i]  = rnd_word();
                    pend_b[i]  = rnd_word();
                end
            end
            req_valid    = {pend_v[1], pend_v[0]};
            req_aluop[0] = pend_op[0];
            req_aluop[1] = pend_op[1];
            req_a[0]     = pend_a[0];
            req_a[1]     = pend_a[1];
            req_b[0]     = pend_b[0];
            req_b[1]     = pend_b[1];
            rsp_ready    = 2'($urandom_range(0, 3));
            #1;
            exp_rv = (m_busy && m_age >= 1) ? (2'b01 << m_owner) : 2'b00;
            check("rnd_rsp_valid", rsp_valid, exp_rv);
            if (exp_rv != 2'b00 && exp_q.size() > 0) begin
                check("rnd_rsp_data", rsp_bus(), exp_q[0]);
            end
            can    = !m_busy || (m_age >= 1 && rsp_ready[m_owner]);
            any    = pend_v[0] || pend_v[1];
            g      = pick_req(pend_v[0], pend_v[1], m_last);
            exp_rr = (can && any) ? (2'b01 << g) : 2'b00;
            check("rnd_req_ready", req_ready, exp_rr);
            if (m_busy && m_age >= 1 && rsp_ready[m_owner]) begin
                void'(exp_q.pop_front());
                m_busy = 1'b0;
            end
            if (can && any) begin
                exp_q.push_back(ref_alu(pend_op[g], pend_a[g], pend_b[g]));
                m_busy    = 1'b1;
                m_owner   = g;
                m_age     = 0;
                m_last    = g;
                pend_v[g] = 1'b0;
            end else if (m_busy) begin
                m_age++;
            end
        end
        @(negedge CLK);
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        repeat (3) @(negedge CLK);

        // Contention: both valid continuously, responses always accepted.
        do_reset();
        begin
            int   ng;
            int   gcyc [4];
            logic gid  [4];
            ng = 0;
            @(negedge CLK);
            req_aluop = {ALU_ADD, ALU_ADD};
            req_a     = {32'd2, 32'd1};
            req_b     = {32'd2, 32'd1};
            req_valid = 2'b11;
            rsp_ready = 2'b11;
            for (int c = 0; c < 20 && ng < 4; c++) begin
                #1;
                if (req_ready != 2'b00) begin
                    gid[ng]  = req_ready[1];
                    gcyc[ng] = c;
                    ng++;
                end
                @(negedge CLK);
            end
            check("cont_grant_count", ng, 4);
            for (int k = 0; k < ng; k++) begin
                check($sformatf("cont_grant%0d", k), gid[k], RR_MODE ? (k % 2) : 0);
            end
            for (int k = 1; k < ng; k++) begin
                check($sformatf("cont_spacing%0d", k), gcyc[k] - gcyc[k-1], 2);
            end
            req_valid = 2'b00;
            repeat (3) @(negedge CLK);
        end

        // Backpressure: r0 response held for 5 cycles while r1 waits.
        do_reset();
        @(negedge CLK);
        req_aluop[0] = ALU_SUB;
        req_a[0]     = 32'd4;
        req_b[0]     = 32'd4;
        req_valid    = 2'b01;
        rsp_ready    = 2'b10;
        #1;
        check("bp_grant0", req_ready, 2'b01);
        @(negedge CLK);
        req_aluop[1] = ALU_ADD;
        req_a[1]     = 32'd1;
        req_b[1]     = 32'd2;
        req_valid    = 2'b10;
        #1;
        check("bp_exec_ready", req_ready, 2'b00);
        check("bp_exec_rsp", rsp_valid, 2'b00);
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            #1;
            check($sformatf("bp_hold_valid%0d", k), rsp_valid, 2'b01);
            check($sformatf("bp_hold_data%0d", k), rsp_bus(), {3'b001, 32'd0});
            check($sformatf("bp_hold_ready%0d", k), req_ready, 2'b00);
        end
        @(negedge CLK);
        rsp_ready = 2'b11;
        #1;
        check("bp_release_grant1", req_ready, 2'b10);
        check("bp_release_valid", rsp_valid, 2'b01);
        @(negedge CLK);
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        #1;
        check("bp_r1_exec", rsp_valid, 2'b00);
        @(negedge CLK);
        #1;
        check("bp_r1_valid", rsp_valid, 2'b10);
        check("bp_r1_data", rsp_bus(), {3'b000, 32'd3});
        rsp_ready = 2'b10;
        @(negedge CLK);
        rsp_ready = 2'b00;

        // Reset during EXEC discards the operation.
        @(negedge CLK);
        req_aluop[0] = ALU_SLT;
        req_a[0]     = 32'hFFFF_FFFF;
        req_b[0]     = 32'h0000_0001;
        req_valid    = 2'b01;
        #1;
        check("rx_grant", req_ready, 2'b01);
        @(negedge CLK);
        req_valid = 2'b00;
        #1;
        check("rx_exec", rsp_valid, 2'b00);
        nRST      = 1'b0;
        req_valid = 2'b11;
        #1;
        check("rx_req_ready", req_ready, 2'b00);
        check("rx_rsp_valid", rsp_valid, 2'b00);
        check("rx_rsp_data", rsp_bus(), 35'd0);
        @(negedge CLK);
        req_valid = 2'b00;
        @(negedge CLK);
        nRST = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            #1;
            check($sformatf("rx_no_rsp%0d", k), rsp_valid, 2'b00);
        end
        do_op(100, 1'b0, ALU_SLT, 32'hFFFF_FFFF, 32'h0000_0001, {3'b000, 32'h0000_0001});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
